// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-code decoder: FSM states and
// width-independent one-hot / successor-index functions.
package ring_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Operates on a zero-extended 32-bit copy so one function serves any WIDTH <= 32.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  function automatic logic [31:0] next_idx(input logic [31:0] cur, input logic [31:0] width);
    return (cur >= width - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot to binary encoder; valid_o is low for zero or
// multi-bit codes, in which case idx_o is not meaningful.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = is_onehot(32'(ring_i));

endmodule

// File: rtl/ring_decoder.sv
// Ring-code monitor: decodes each sampled one-hot code, locks after LOCK_N
// consecutive correct advances, and flags/counts code or sequence errors.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int IDX_W  = $clog2(WIDTH),
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  state_t             state_q, state_d;
  logic [GOOD_W-1:0]  good_q, good_d, good_inc;
  logic [IDX_W-1:0]   idx_q, idx_d, nxt_idx, enc_idx;
  logic               idx_vld_q, idx_vld_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   cnt_q, cnt_d;
  logic               enc_valid, expected;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .ring_i  (ring_in),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign nxt_idx  = IDX_W'(next_idx(32'(idx_q), 32'(WIDTH)));
  assign expected = (enc_idx == nxt_idx);
  assign good_inc = good_q + GOOD_W'(1);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    idx_d     = idx_q;
    idx_vld_d = idx_vld_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;

    if (ring_vld) begin
      idx_vld_d = enc_valid;
      if (enc_valid) idx_d = enc_idx;

      unique case (state_q)
        ST_HUNT: begin
          if (enc_valid) begin
            state_d = ST_CONFIRM;
            good_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (!enc_valid) begin
            state_d = ST_HUNT;
            good_d  = '0;
            err_d   = 1'b1;
          end else if (expected) begin
            if (good_inc == GOOD_W'(LOCK_N)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            // Not yet locked: silently restart the confirm run at the new index.
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!enc_valid) begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
          end else if (expected) begin
            wrap_d = (idx_q == IDX_W'(WIDTH - 1));
          end else begin
            state_d = ST_CONFIRM;
            good_d  = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_HUNT;
          good_d  = '0;
        end
      endcase
    end

    cnt_d = cnt_q;
    if (err_d && (cnt_q != '1)) cnt_d = cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_HUNT;
      good_q    <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      idx_q     <= idx_d;
      idx_vld_q <= idx_vld_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign idx     = idx_q;
  assign idx_vld = idx_vld_q;
  assign locked  = (state_q == ST_LOCKED);
  assign wrap    = wrap_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule
